fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the decode/execute stage.
- Issues word fetches to instruction memory through a request/grant/response handshake, with at most one request outstanding.
- Buffers fetched words with their PC in a small FIFO, splits the FIFO head into opcode/func3/func7/rd/rs1/rs2 and a sign-extended immediate, and presents them with a valid/ready handshake.
- Accepts PC redirects (branches, jumps) from downstream and flushes wrong-path instructions.

Parameters:
- DEPTH, 4, instruction FIFO entries (power of two, at least 2)
- RESET_PC, 32'h0000_0000, fetch address after reset

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  reset, synchronous, active-high
- imem_req  out  1  fetch request valid
- imem_addr  out  32  fetch address, word aligned
- imem_gnt  in  1  memory accepts the request this cycle
- imem_rvalid  in  1  response data valid
- imem_rdata  in  32  instruction word
- redirect_valid  in  1  PC change from downstream
- redirect_pc  in  32  new fetch address (bits [1:0] ignored, forced to 0)
- out_valid  out  1  FIFO head is a valid instruction
- out_ready  in  1  downstream consumes the head
- out_pc  out  32  PC of the head instruction
- opcode  out  7  instr[6:0]
- rd  out  5  instr[11:7]
- func3  out  3  instr[14:12]
- rs1  out  5  instr[19:15]
- rs2  out  5  instr[24:20]
- func7  out  7  instr[31:25]
- imm  out  32  sign-extended immediate of the head

Behaviour:
- Reset:
  - fetch_pc = RESET_PC; FIFO empty; state RUN.
  - imem_req = 0, out_valid = 0.
  - All field outputs and imm = 0 while out_valid = 0.
- States:
  - RUN: imem_req = (count < DEPTH); imem_addr = fetch_pc.
    - req & gnt: fetch_pc += 4 (wraps modulo 2^32), go to WAIT.
  - WAIT: imem_req = 0.
    - rvalid: push {pc_of_request, rdata}, go to RUN.
  - KILL: imem_req = 0.
    - rvalid: drop the data, go to RUN.
- The address and PC of the outstanding request are captured at grant. While req = 1 without gnt, the address is held stable.
- Response latency is 1 cycle or more after grant; rvalid never arrives in the grant cycle. The earliest new request is the cycle after the rvalid push.
- Output handshake:
  - out_valid = (count != 0).
  - Pop on out_valid & out_ready.
  - Push and pop in the same cycle leave count unchanged.
  - Push into a full FIFO cannot occur, because no request is issued when count == DEPTH.
- Redirect (highest priority, takes effect at the edge):
  - FIFO cleared; fetch_pc = redirect_pc & ~3.
  - In RUN without gnt: stay in RUN.
  - In RUN with gnt in the same cycle: the granted request counts as outstanding; go to KILL.
  - In WAIT without rvalid: go to KILL.
  - In WAIT with rvalid: data dropped; go to RUN.
  - In KILL: stay in KILL, or go to RUN if rvalid.
  - A pop in the same cycle as a redirect is ignored.
  - out_valid = 0 in the cycle after a redirect.
- Immediate generation is combinational on the FIFO head, selected by opcode:
  - I-type (0010011, 0000011, 1100111): sext(instr[31:20]).
  - S-type (0100011): sext({instr[31:25], instr[11:7]}).
  - B-type (1100011): sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}).
  - U-type (0110111, 0010111): {instr[31:12], 12'b0}.
  - J-type (1101111): sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).
  - Any other opcode: imm = 0.
- Reset asserted mid-transaction: state returns to RUN and the FIFO empties. A later rvalid arriving in RUN is ignored. The memory must discard its pending response on reset.
- Latency: a granted fetch appears on out_valid the cycle after rvalid.

Decomposition:
- Shared package (defines):
  - opcode constants (OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC), shared with decode.
  - fetch state encodings FS_RUN, FS_WAIT, FS_KILL.
- Sub-module imm_gen: purely combinational, instr[31:0] -> imm[31:0]. Decode reuses it.
- FIFO storage is inline as a register array with read/write pointers and a count.

Test Plan:
- Reset release, gnt tied to 1, rvalid one cycle after grant, imem returns 0x00500093 at address 0:
  - out_valid with out_pc = 0, opcode = 0x13, rd = 1, rs1 = 0, func3 = 0, imm = 5.
  - Next request address = 4.
- Stream of 0x0020A423, 0xFE000EE3, 0x010000EF, 0x123452B7:
  - imm sequence 8, 0xFFFFFFFC, 16, 0x12345000.
  - opcodes 0x23, 0x63, 0x6F, 0x37.
- out_ready = 0 for 10 cycles:
  - Exactly 4 words fetched (addresses 0, 4, 8, 0xC), then imem_req = 0.
  - After one pop, a request to 0x10 resumes.
- Redirect to 0x103 while in WAIT, rvalid arriving 2 cycles later with 0xDEADBEEF:
  - Data dropped, out_valid stays 0.
  - Next request address = 0x100.
- Redirect in the same cycle as gnt, and separately in the same cycle as rvalid:
  - Neither response reaches the FIFO.
  - Fetch restarts at the redirect target.
- Reset asserted while in WAIT:
  - Next cycle imem_req = 1, imem_addr = RESET_PC, out_valid = 0.
  - A stale rvalid after reset is ignored.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch stage: RV32 base opcodes (also used by
// decode) and the fetch FSM state encoding.
package fetch_unit_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    // RUN: free to request; WAIT: one request outstanding, response wanted;
    // KILL: one request outstanding whose response belongs to a dead path.
    typedef enum logic [1:0] {
        FS_RUN  = 2'd0,
        FS_WAIT = 2'd1,
        FS_KILL = 2'd2
    } fetchState_t;

endpackage

// File: rtl/fetch_unit_imm_gen.sv
// Immediate generator: purely combinational, shared between fetch and decode.
module imm_gen
    import fetch_unit_pkg::*;
(
    input  logic [31:0] instr,
    output logic [31:0] imm
);

    // Select the immediate format from the opcode and sign-extend it.
    always_comb begin
        // NOTE: default assignment first so no opcode path leaves imm unassigned (no latch).
        imm = '0;
        case (instr[6:0])
            OP_I, OP_LOAD, OP_JALR:
                imm = {{20{instr[31]}}, instr[31:20]};
            OP_STORE:
                imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            OP_BRANCH:
                imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            OP_LUI, OP_AUIPC:
                imm = {instr[31:12], 12'b0};
            OP_JAL:
                imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default:
                imm = '0;
        endcase
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: one-outstanding-request memory interface, a small
// instruction FIFO with PCs, field split and immediate generation of the head,
// and downstream PC redirects that flush the wrong path.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
)
(
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [6:0]  opcode,
    output logic [4:0]  rd,
    output logic [2:0]  func3,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [6:0]  func7,
    output logic [31:0] imm
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    fetchState_t      state;
    logic [31:0]      fetchPc;
    logic [31:0]      reqPc;
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;
    logic [CNT_W-1:0] count;

    logic [31:0]      pcMem    [DEPTH];
    logic [31:0]      instrMem [DEPTH];

    logic             grant;
    logic             push;
    logic             pop;
    logic             headValid;
    logic [31:0]      headInstr;
    logic [31:0]      headPc;
    logic [31:0]      headImm;

    // Request only when free and there is room for the response; the address
    // is the registered fetch PC, so it stays stable until granted.
    assign imem_req  = !reset && (state == FS_RUN) && (count < FULL_COUNT);
    assign imem_addr = fetchPc;
    assign grant     = imem_req && imem_gnt;

    // A redirect kills both the in-flight response and any head consumption.
    assign push      = (state == FS_WAIT) && imem_rvalid && !redirect_valid;
    assign headValid = (count != '0);
    assign pop       = headValid && out_ready && !redirect_valid;

    // Fetch FSM, PC tracking and FIFO pointers/occupancy.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state   <= FS_RUN;
            fetchPc <= RESET_PC;
            reqPc   <= RESET_PC;
            wrPtr   <= '0;
            rdPtr   <= '0;
            count   <= '0;
        end else if (redirect_valid) begin
            fetchPc <= redirect_pc & ~32'd3;
            wrPtr   <= '0;
            rdPtr   <= '0;
            count   <= '0;
            case (state)
                FS_RUN:  state <= grant ? FS_KILL : FS_RUN;
                FS_WAIT: state <= imem_rvalid ? FS_RUN : FS_KILL;
                FS_KILL: state <= imem_rvalid ? FS_RUN : FS_KILL;
                default: state <= FS_RUN;
            endcase
        end else begin
            case (state)
                FS_RUN: begin
                    if (grant) begin
                        reqPc   <= fetchPc;
                        fetchPc <= fetchPc + 32'd4;
                        state   <= FS_WAIT;
                    end
                end
                FS_WAIT: if (imem_rvalid) state <= FS_RUN;
                FS_KILL: if (imem_rvalid) state <= FS_RUN;
                default: state <= FS_RUN;
            endcase

            if (push) wrPtr <= wrPtr + 1'b1;
            if (pop)  rdPtr <= rdPtr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // FIFO storage write: PC of the outstanding request alongside its word.
    always_ff @(posedge clk) begin
        // NOTE: FIFO storage is deliberately not reset; count gates every read, so stale entries are never visible.
        if (!reset && push) begin
            pcMem[wrPtr]    <= reqPc;
            instrMem[wrPtr] <= imem_rdata;
        end
    end

    assign headInstr = instrMem[rdPtr];
    assign headPc    = pcMem[rdPtr];

    imm_gen u_imm_gen (
        .instr (headInstr),
        .imm   (headImm)
    );

    // Present the head; all fields read as zero while nothing is valid.
    assign out_valid = headValid;
    assign out_pc    = headValid ? headPc           : '0;
    assign opcode    = headValid ? headInstr[6:0]   : '0;
    assign rd        = headValid ? headInstr[11:7]  : '0;
    assign func3     = headValid ? headInstr[14:12] : '0;
    assign rs1       = headValid ? headInstr[19:15] : '0;
    assign rs2       = headValid ? headInstr[24:20] : '0;
    assign func7     = headValid ? headInstr[31:25] : '0;
    assign imm       = headValid ? headImm          : '0;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a behavioural instruction memory driven once
// per cycle, a table of decoded-instruction vectors, and hand-written
// sequences for back-pressure, redirects and mid-transaction reset.
module tb_fetch_unit;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  func3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  func7;
    logic [31:0] imm;

    fetch_unit #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .opcode         (opcode),
        .rd             (rd),
        .func3          (func3),
        .rs1            (rs1),
        .rs2            (rs2),
        .func7          (func7),
        .imm            (imm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [6:0]  f7;
        logic [31:0] imm;
    } vec_t;

    vec_t        vecs [8];
    logic [31:0] rom  [256];
    logic [31:0] reqLog [$];
    int          checks;
    int          failures;
    int          pendCnt;
    logic [31:0] pendAddr;
    int          latency;
    bit          autoMem;
    int          protoErr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Memory model: response pendCnt cycles after grant, gnt always high.
    task automatic memStep();
        #1;
        if (!autoMem) return;
        imem_rvalid = 1'b0;
        if (pendCnt == 1) begin
            imem_rvalid = 1'b1;
            imem_rdata  = rom[pendAddr[9:2]];
            pendCnt     = 0;
        end else if (pendCnt > 1) begin
            pendCnt--;
        end
        imem_gnt = 1'b1;
        if (imem_req) begin
            if (pendCnt != 0 || imem_rvalid) begin
                protoErr++;
            end else begin
                pendAddr = imem_addr;
                pendCnt  = latency;
                reqLog.push_back(imem_addr);
            end
        end
    endtask

    // One clock: memory reacts, edge happens, return at the falling edge.
    task automatic cycle();
        memStep();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic doReset();
        reset          = 1'b1;
        redirect_valid = 1'b0;
        out_ready      = 1'b0;
        autoMem        = 1'b1;
        pendCnt        = 0;
        imem_rvalid    = 1'b0;
        imem_gnt       = 1'b0;
        cycle();
        cycle();
        reset = 1'b0;
        reqLog.delete();
    endtask

    task automatic waitValid(input string name);
        int n;
        n = 0;
        while (!out_valid && n < 40) begin
            cycle();
            n++;
        end
        check({name, "_valid"}, 32'(out_valid), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        checks   = 0;
        failures = 0;
        protoErr = 0;
        latency  = 1;
        pendCnt  = 0;
        pendAddr = '0;
        autoMem  = 1'b1;
        reset          = 1'b1;
        imem_gnt       = 1'b0;
        imem_rvalid    = 1'b0;
        imem_rdata     = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        out_ready      = 1'b0;
        for (int i = 0; i < 256; i++) rom[i] = '0;

        vecs[0] = '{32'h00500093, 32'h00, 7'h13, 5'd1,  3'd0, 5'd0,  5'd5,  7'h00, 32'h00000005};
        vecs[1] = '{32'h0020A423, 32'h04, 7'h23, 5'd8,  3'd2, 5'd1,  5'd2,  7'h00, 32'h00000008};
        vecs[2] = '{32'hFE000EE3, 32'h08, 7'h63, 5'd29, 3'd0, 5'd0,  5'd0,  7'h7F, 32'hFFFFFFFC};
        vecs[3] = '{32'h010000EF, 32'h0C, 7'h6F, 5'd1,  3'd0, 5'd0,  5'd16, 7'h00, 32'h00000010};
        vecs[4] = '{32'h123452B7, 32'h10, 7'h37, 5'd5,  3'd5, 5'd8,  5'd3,  7'h09, 32'h12345000};
        vecs[5] = '{32'hFFC12083, 32'h14, 7'h03, 5'd1,  3'd2, 5'd2,  5'd28, 7'h7F, 32'hFFFFFFFC};
        vecs[6] = '{32'h002081B3, 32'h18, 7'h33, 5'd3,  3'd0, 5'd1,  5'd2,  7'h00, 32'h00000000};
        vecs[7] = '{32'hFFFFFFFF, 32'h1C, 7'h7F, 5'd31, 3'd7, 5'd31, 5'd31, 7'h7F, 32'h00000000};
        for (int i = 0; i < 8; i++) rom[i] = vecs[i].instr;

        // Reset state
        cycle();
        cycle();
        check("rst_req",    32'(imem_req),  32'd0);
        check("rst_valid",  32'(out_valid), 32'd0);
        check("rst_opcode", 32'(opcode),    32'd0);
        check("rst_imm",    imm,            32'd0);
        reset = 1'b0;
        #1;
        check("rst_release_addr", imem_addr, 32'h0);

        // Table-driven stream with free-flowing output
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            waitValid($sformatf("vec%0d", i));
            check($sformatf("vec%0d_pc", i),    out_pc,       vecs[i].pc);
            check($sformatf("vec%0d_op", i),    32'(opcode),  32'(vecs[i].op));
            check($sformatf("vec%0d_rd", i),    32'(rd),      32'(vecs[i].rd));
            check($sformatf("vec%0d_f3", i),    32'(func3),   32'(vecs[i].f3));
            check($sformatf("vec%0d_rs1", i),   32'(rs1),     32'(vecs[i].rs1));
            check($sformatf("vec%0d_rs2", i),   32'(rs2),     32'(vecs[i].rs2));
            check($sformatf("vec%0d_f7", i),    32'(func7),   32'(vecs[i].f7));
            check($sformatf("vec%0d_imm", i),   imm,          vecs[i].imm);
            if (i == 0) begin
                check("first_next_req",  32'(imem_req), 32'd1);
                check("first_next_addr", imem_addr,     32'h4);
            end
            cycle();
        end

        // Back-pressure: FIFO fills with exactly DEPTH words, then stalls
        doReset();
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) cycle();
        check("bp_req_count", 32'(reqLog.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < reqLog.size()) check($sformatf("bp_addr%0d", i), reqLog[i], 32'(4 * i));
        end
        check("bp_req_stall", 32'(imem_req),  32'd0);
        check("bp_valid",     32'(out_valid), 32'd1);
        check("bp_head_pc",   out_pc,         32'h0);
        out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;
        #1;
        check("bp_resume_req",  32'(imem_req), 32'd1);
        check("bp_resume_addr", imem_addr,     32'h10);
        check("bp_next_pc",     out_pc,        32'h4);

        // Redirect while WAIT, response two cycles later is dropped
        doReset();
        out_ready = 1'b1;
        latency   = 3;
        rom[0]    = 32'hDEADBEEF;
        rom[64]   = 32'h00100113;
        cycle();
        check("rw_wait_req", 32'(imem_req), 32'd0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h103;
        cycle();
        redirect_valid = 1'b0;
        check("rw_kill_valid", 32'(out_valid), 32'd0);
        check("rw_kill_req",   32'(imem_req),  32'd0);
        cycle();
        check("rw_kill_valid2", 32'(out_valid), 32'd0);
        cycle();
        check("rw_drop_valid", 32'(out_valid), 32'd0);
        check("rw_restart_req",  32'(imem_req), 32'd1);
        check("rw_restart_addr", imem_addr,     32'h100);
        latency = 1;
        waitValid("rw_target");
        check("rw_target_pc",  out_pc,    32'h100);
        check("rw_target_rd",  32'(rd),   32'd2);
        check("rw_target_imm", imm,       32'd1);

        // Redirect in the grant cycle
        doReset();
        out_ready = 1'b1;
        rom[128]  = 32'h123452B7;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        cycle();
        redirect_valid = 1'b0;
        check("rg_valid", 32'(out_valid), 32'd0);
        check("rg_kill_req", 32'(imem_req), 32'd0);
        cycle();
        check("rg_drop_valid", 32'(out_valid), 32'd0);
        check("rg_restart_req",  32'(imem_req), 32'd1);
        check("rg_restart_addr", imem_addr,     32'h200);
        waitValid("rg_target");
        check("rg_target_pc",  out_pc, 32'h200);
        check("rg_target_imm", imm,    32'h12345000);

        // Redirect in the rvalid cycle
        doReset();
        out_ready = 1'b1;
        rom[192]  = 32'h010000EF;
        cycle();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h300;
        cycle();
        redirect_valid = 1'b0;
        check("rr_drop_valid",   32'(out_valid), 32'd0);
        check("rr_restart_req",  32'(imem_req),  32'd1);
        check("rr_restart_addr", imem_addr,      32'h300);
        waitValid("rr_target");
        check("rr_target_pc",  out_pc, 32'h300);
        check("rr_target_imm", imm,    32'h10);

        // Reset while WAIT, then a stale response
        doReset();
        out_ready = 1'b1;
        rom[0]    = 32'h00500093;
        cycle();
        check("rs_wait_req", 32'(imem_req), 32'd0);
        reset   = 1'b1;
        pendCnt = 0;
        cycle();
        reset = 1'b0;
        #1;
        check("rs_req",   32'(imem_req),  32'd1);
        check("rs_addr",  imem_addr,      32'h0);
        check("rs_valid", 32'(out_valid), 32'd0);
        autoMem     = 1'b0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEADBEEF;
        cycle();
        imem_rvalid = 1'b0;
        #1;
        check("rs_stale_valid", 32'(out_valid), 32'd0);
        check("rs_stale_req",   32'(imem_req),  32'd1);
        check("rs_stale_addr",  imem_addr,      32'h0);
        autoMem = 1'b1;
        waitValid("rs_fetch");
        check("rs_fetch_pc",  out_pc, 32'h0);
        check("rs_fetch_imm", imm,    32'd5);

        check("protocol_errors", 32'(protoErr), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
